// File: rtl/eth_rx_dma_pkg.sv
// rtl/eth_rx_dma_pkg.sv - shared state encoding and default window constants for eth_rx_dma
package eth_rx_dma_pkg;

    localparam logic [7:0] BASE_ADDR_DEF  = 8'hE0;
    localparam int         MAX_LEN_DEF    = 16;
    localparam int         FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // States in which the block may own the RAM port.
    function automatic logic owns_port(input state_e st);
        return (st == ST_RECV) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/eth_rx_dma_byte_fifo.sv
// rtl/eth_rx_dma_byte_fifo.sv - small byte FIFO; push on full is accepted only alongside a pop
module eth_rx_dma_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_dma.sv
// rtl/eth_rx_dma.sv - stores a received payload into a fixed RAM window and reports length to the CPU
module eth_rx_dma
    import eth_rx_dma_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter int         MAX_LEN    = MAX_LEN_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_last,
    input  logic       mem_grant,
    input  logic       ack,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_wren,
    output logic       done,
    output logic [7:0] frame_len,
    output logic       overflow
);
    state_e     state_q;
    logic [7:0] wr_idx_q;
    logic [8:0] byte_cnt_q;
    logic [7:0] frame_len_q;
    logic       done_q;
    logic       overflow_q;

    logic       accepting;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] fifo_dout;

    assign accepting = (state_q == ST_IDLE) || (state_q == ST_RECV);
    assign fifo_pop  = ~fifo_empty & mem_grant & owns_port(state_q);
    assign fifo_push = rx_valid & accepting & (byte_cnt_q < 9'(MAX_LEN))
                     & (~fifo_full | fifo_pop);

    eth_rx_dma_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (rx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_idx_q    <= 8'd0;
            byte_cnt_q  <= 9'd0;
            frame_len_q <= 8'd0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                wr_idx_q <= wr_idx_q + 8'd1;
            end
            if (fifo_push) begin
                byte_cnt_q <= byte_cnt_q + 9'd1;
            end
            // Bytes offered while receiving but not taken are lost for good.
            if (rx_valid && accepting && !fifo_push) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        state_q <= rx_last ? ST_DRAIN : ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rx_valid && rx_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        frame_len_q <= wr_idx_q;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_q    <= ST_IDLE;
                        done_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        wr_idx_q   <= 8'd0;
                        byte_cnt_q <= 9'd0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_wren  = fifo_pop;
    assign mem_req   = fifo_pop;
    assign mem_addr  = BASE_ADDR + wr_idx_q;
    assign mem_data  = fifo_dout;
    assign done      = done_q;
    assign frame_len = frame_len_q;
    assign overflow  = overflow_q;

endmodule
